// File: rtl/gate_test_sequencer.sv
// Runs a four-vector truth-table check against a 2-input gate under test.
// It reports the per-vector mismatches and a pass flag.
module gate_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] func_sel,
  input  logic       dut_out,
  output logic       dut_in1,
  output logic       dut_in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] err_vec
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned FSEL_W = 3;
  localparam int unsigned ERR_W  = 3;
  localparam int unsigned VEC_N  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FSEL_W-1:0]   fsel_q, fsel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ERR_W-1:0]    ecnt_d;
  logic [VEC_N-1:0]    evec_d;
  logic                exp_bit;
  logic                mismatch;
  logic                busy_d, done_d, pass_d, in1_d, in2_d;

  // Expected gate output for the current vector under the latched function.
  always_comb begin
    exp_bit = 1'b0;
    case (fsel_q)
      3'd0:    exp_bit = ~(idx_q[1] & idx_q[0]);
      3'd1:    exp_bit =   idx_q[1] & idx_q[0];
      3'd2:    exp_bit =   idx_q[1] | idx_q[0];
      3'd3:    exp_bit = ~(idx_q[1] | idx_q[0]);
      3'd4:    exp_bit =   idx_q[1] ^ idx_q[0];
      3'd5:    exp_bit = ~(idx_q[1] ^ idx_q[0]);
      3'd6:    exp_bit = ~idx_q[1];
      default: exp_bit =  idx_q[1];
    endcase
  end

  // Only a clean equal compare passes; an unknown compare result lands in the else arm.
  always_comb begin
    mismatch = 1'b1;
    if (dut_out == exp_bit) begin
      mismatch = 1'b0;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fsel_d  = fsel_q;
    cnt_d   = cnt_q;
    ecnt_d  = err_count;
    evec_d  = err_vec;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          fsel_d  = func_sel;
          ecnt_d  = '0;
          evec_d  = '0;
          idx_d   = '0;
          state_d = APPLY;
        end
      end
      APPLY: begin
        cnt_d   = CNT_W'(SETTLE_CYCLES);
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CHECK: begin
        if (mismatch) begin
          evec_d[idx_q] = 1'b1;
          if (err_count < ERR_W'(VEC_N)) begin
            ecnt_d = err_count + ERR_W'(1);
          end
        end
        if (idx_q == IDX_W'(VEC_N - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == APPLY) || (state_d == SETTLE) || (state_d == CHECK);
    done_d = (state_d == DONE);
    pass_d = done_d && (ecnt_d == '0);
    in1_d  = busy_d & idx_d[1];
    in2_d  = busy_d & idx_d[0];
  end

  // State and registered outputs; reset wins over everything.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      fsel_q    <= '0;
      cnt_q     <= '0;
      err_count <= '0;
      err_vec   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      dut_in1   <= 1'b0;
      dut_in2   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      fsel_q    <= fsel_d;
      cnt_q     <= cnt_d;
      err_count <= ecnt_d;
      err_vec   <= evec_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      dut_in1   <= in1_d;
      dut_in2   <= in2_d;
    end
  end

endmodule
